// File: rtl/iq_avg_snap_ctrl.sv
// IQ boxcar-average snapshot capture: averages 2^k valid I/Q samples per word and writes 2^ADDR_W words to BRAM port A.
// Optional IQ_SNAP_ROUND_EN: round-half-up averaging instead of floor truncation.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | k latched, waiting for trig
// CAPTURE | accumulating samples and writing averaged words
// DONE    | buffer full, waiting for arm
module iq_avg_snap_ctrl #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 10,
    parameter int AVG_MAX_LOG2 = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_i,
    input  logic [DATA_W-1:0]     in_q,
    input  logic [2:0]            avg_log2,
    input  logic                  arm,
    input  logic                  trig,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_we,
    output logic                  bram_en_a,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [2*DATA_W-1:0]   bram_wr_data
);

    localparam int ACC_W = DATA_W + AVG_MAX_LOG2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]               state;
    logic [2:0]               k;
    logic [2:0]               k_arm;
    logic [AVG_MAX_LOG2-1:0]  cnt;
    logic [AVG_MAX_LOG2-1:0]  cnt_load;
    logic [AVG_MAX_LOG2-1:0]  cnt_load_arm;
    logic signed [ACC_W-1:0]  acc_i;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum_i;
    logic signed [ACC_W-1:0]  sum_q;
    logic signed [ACC_W-1:0]  rnd;
    logic [DATA_W-1:0]        res_i;
    logic [DATA_W-1:0]        res_q;
    logic [ADDR_W-1:0]        wr_addr;
    logic                     fin;
    logic                     take;

    assign k_arm = ({1'b0, avg_log2} > 4'(AVG_MAX_LOG2)) ? 3'(AVG_MAX_LOG2) : avg_log2;

    // Sample counter runs down from 2^k-1; a word completes at terminal count 0.
    assign cnt_load     = ~({AVG_MAX_LOG2{1'b1}} << k);
    assign cnt_load_arm = ~({AVG_MAX_LOG2{1'b1}} << k_arm);

    assign sum_i = acc_i + $signed({{AVG_MAX_LOG2{in_i[DATA_W-1]}}, in_i});
    assign sum_q = acc_q + $signed({{AVG_MAX_LOG2{in_q[DATA_W-1]}}, in_q});

`ifdef IQ_SNAP_ROUND_EN
    assign rnd = (k == 3'd0) ? '0 : (ACC_W'(1) << (k - 3'd1));
`else
    assign rnd = '0;
`endif

    assign res_i = DATA_W'((sum_i + rnd) >>> k);
    assign res_q = DATA_W'((sum_q + rnd) >>> k);

    // fin blocks sample acceptance during the final strobe cycle so the address never wraps.
    always_comb begin
        take = 1'b0;
        if (!arm && in_valid) begin
            take = (state == S_ARMED && trig) || (state == S_CAPTURE && !fin);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            k            <= '0;
            cnt          <= '0;
            acc_i        <= '0;
            acc_q        <= '0;
            wr_addr      <= '0;
            fin          <= 1'b0;
            bram_we      <= 1'b0;
            bram_addr    <= '0;
            bram_wr_data <= '0;
        end else begin
            bram_we <= 1'b0;
            if (arm) begin
                state   <= S_ARMED;
                k       <= k_arm;
                cnt     <= cnt_load_arm;
                acc_i   <= '0;
                acc_q   <= '0;
                wr_addr <= '0;
                fin     <= 1'b0;
            end else begin
                if (state == S_ARMED && trig) begin
                    state <= S_CAPTURE;
                end
                if (state == S_CAPTURE && fin) begin
                    state <= S_DONE;
                end
                if (take) begin
                    if (cnt == '0) begin
                        bram_we      <= 1'b1;
                        bram_addr    <= wr_addr;
                        bram_wr_data <= {res_i, res_q};
                        wr_addr      <= wr_addr + 1'b1;
                        acc_i        <= '0;
                        acc_q        <= '0;
                        cnt          <= cnt_load;
                        if (wr_addr == '1) begin
                            fin <= 1'b1;
                        end
                    end else begin
                        acc_i <= sum_i;
                        acc_q <= sum_q;
                        cnt   <= cnt - 1'b1;
                    end
                end
            end
        end
    end

    assign busy      = (state == S_ARMED) || (state == S_CAPTURE);
    assign done      = (state == S_DONE);
    assign bram_en_a = bram_we;

endmodule

// File: tb/tb_iq_avg_snap_ctrl.sv
// Bench for iq_avg_snap_ctrl: random and directed I/Q streams scored against an arithmetic average model.
module tb_iq_avg_snap_ctrl;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int NW = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_i = '0;
    logic [DW-1:0]   in_q = '0;
    logic [2:0]      avg_log2 = '0;
    logic            arm = 1'b0;
    logic            trig = 1'b0;
    logic            busy;
    logic            done;
    logic            bram_we;
    logic            bram_en_a;
    logic [AW-1:0]   bram_addr;
    logic [2*DW-1:0] bram_wr_data;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    logic [31:0] word0 = '0;

    typedef struct {
        int          due;
        int          addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    iq_avg_snap_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
        .avg_log2(avg_log2), .arm(arm), .trig(trig), .busy(busy), .done(done),
        .bram_we(bram_we), .bram_en_a(bram_en_a), .bram_addr(bram_addr),
        .bram_wr_data(bram_wr_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int floor_div(input int s, input int d);
        if (s >= 0) return s / d;
        return -((-s + d - 1) / d);
    endfunction

    function automatic int avg_val(input int s, input int k);
        int d;
        int t;
        d = 1 << k;
        t = s;
`ifdef IQ_SNAP_ROUND_EN
        if (k > 0) t = t + d / 2;
`endif
        return floor_div(t, d);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every cycle the strobe must match exactly the words the model has due.
    always @(negedge clk) begin
        if (rst_n) begin
            bit ew;
            ew = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("bram_we", bram_we, ew);
            check("bram_en_a", bram_en_a, ew);
            if (bram_we && ew) begin
                check("bram_addr", bram_addr, exp_q[0].addr);
                check("bram_wr_data", bram_wr_data, exp_q[0].data);
                if (exp_q[0].addr == 0) word0 = bram_wr_data;
                wr_cnt++;
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int k);
        avg_log2 = 3'(k);
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // mode 0: I=n,Q=-n  1: random  2: full-scale positive  3: 1,2,3,4 / -1..-4 repeating
    task automatic run(input int k, input int nwords, input int mode, input bit gaps);
        int n;
        bit first;
        int si, sq, vi, vq;
        logic signed [15:0] r;
        n = 0;
        first = 1'b1;
        wr_cnt = 0;
        for (int w = 0; w < nwords; w++) begin
            si = 0;
            sq = 0;
            for (int j = 0; j < (1 << k); j++) begin
                if (gaps && !first) begin
                    for (int g = 0; g < 8 && $urandom_range(1, 0) == 0; g++) begin
                        in_valid = 1'b0;
                        trig = 1'b0;
                        in_i = 16'($urandom);
                        in_q = 16'($urandom);
                        tick();
                    end
                end
                case (mode)
                    0: begin vi = n; vq = -n; end
                    1: begin r = 16'($urandom); vi = r; r = 16'($urandom); vq = r; end
                    2: begin vi = 32767; vq = 32767; end
                    default: begin vi = (n % 4) + 1; vq = -vi; end
                endcase
                in_valid = 1'b1;
                trig = first;
                in_i = 16'(vi);
                in_q = 16'(vq);
                first = 1'b0;
                si += vi;
                sq += vq;
                n++;
                if (j == (1 << k) - 1) begin
                    exp_q.push_back('{due: cyc + 1, addr: w,
                                      data: {16'(avg_val(si, k)), 16'(avg_val(sq, k))}});
                end
                tick();
            end
        end
        in_valid = 1'b0;
        trig = 1'b0;
    endtask

    task automatic finish_check(input string tag);
        @(negedge clk);
        check({tag, "_done_at_last_strobe"}, done, 1'b0);
        check({tag, "_busy_at_last_strobe"}, busy, 1'b1);
        @(negedge clk);
        check({tag, "_done_after"}, done, 1'b1);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_write_count"}, wr_cnt, NW);
        check({tag, "_pending"}, exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check({tag, "_done_hold"}, done, 1'b1);
        #1;
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_we", bram_we, 1'b0);
        check("rst_en_a", bram_en_a, 1'b0);
        check("rst_addr", bram_addr, 0);
        check("rst_data", bram_wr_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        do_arm(0);
        check("armed_busy", busy, 1'b1);
        check("armed_done", done, 1'b0);
        run(0, NW, 0, 1'b0);
        finish_check("k0_ramp");

        do_arm(2);
        check("rearm_done_clear", done, 1'b0);
        run(2, NW, 3, 1'b0);
        finish_check("k2_pattern");
`ifdef IQ_SNAP_ROUND_EN
        check("k2_word0", word0, 32'h0003_FFFE);
`else
        check("k2_word0", word0, 32'h0002_FFFD);
`endif

        do_arm(0);
        run(0, 300, 1, 1'b0);
        arm = 1'b1;
        avg_log2 = 3'd1;
        in_valid = 1'b1;
        in_i = 16'($urandom);
        in_q = 16'($urandom);
        tick();
        arm = 1'b0;
        check("restart_writes", wr_cnt, 300);
        check("restart_done", done, 1'b0);
        check("restart_busy", busy, 1'b1);
        repeat (6) begin
            in_valid = 1'b1;
            in_i = 16'($urandom);
            in_q = 16'($urandom);
            tick();
        end
        check("armed_no_trig_writes", wr_cnt, 300);
        check("armed_no_trig_done", done, 1'b0);
        run(1, NW, 1, 1'b1);
        finish_check("k1_gaps");

        do_arm(7);
        run(7, 20, 2, 1'b0);
        repeat (5) begin
            in_valid = 1'b1;
            in_i = 16'h7FFF;
            in_q = 16'h7FFF;
            tick();
        end
        check("k7_writes", wr_cnt, 20);
        check("k7_word0", word0, 32'h7FFF_7FFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_we", bram_we, 1'b0);
        check("async_rst_en_a", bram_en_a, 1'b0);
        check("async_rst_addr", bram_addr, 0);
        check("async_rst_data", bram_wr_data, 0);
        exp_q.delete();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        wr_cnt = 0;
        repeat (4) begin
            trig = 1'b1;
            in_valid = 1'b1;
            in_i = 16'($urandom);
            in_q = 16'($urandom);
            tick();
        end
        trig = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();
        check("post_rst_trig_writes", wr_cnt, 0);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_done", done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
